// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: address map, FSM states and address decode shared by the memory responder.
package mem_responder_pkg;

    localparam logic [15:0] ADDR_IO_OUT = 16'hFFF0;
    localparam logic [15:0] ADDR_IO_IN  = 16'hFFF1;
    localparam logic [15:0] ADDR_CYCLES = 16'hFFF2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        SEL_RAM,
        SEL_IO_OUT,
        SEL_IO_IN,
        SEL_CYC,
        SEL_NONE
    } sel_e;

    function automatic sel_e decode(input logic [31:0] a, input int unsigned depth);
        return (a < depth)               ? SEL_RAM    :
               (a == 32'(ADDR_IO_OUT))   ? SEL_IO_OUT :
               (a == 32'(ADDR_IO_IN))    ? SEL_IO_IN  :
               (a == 32'(ADDR_CYCLES))   ? SEL_CYC    : SEL_NONE;
    endfunction

endpackage

// File: rtl/mem_responder_sync_ram.sv
// sync_ram: single-port RAM with synchronous write and registered read.
module sync_ram #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Read data only moves on a read, so it holds the last RAM read value.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[addr] <= wdata;
            else    rdata_q   <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// mem_responder: req/ready memory responder over on-chip RAM plus IO_OUT, IO_IN and CYCLES registers.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int WORD_SIZE   = 16,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mem_req,
    input  logic                 mem_we,
    input  logic [WORD_SIZE-1:0] memory_addr,
    input  logic [WORD_SIZE-1:0] memory_out,
    output logic [WORD_SIZE-1:0] memory_in,
    output logic                 mem_ready,
    output logic                 mem_fault,
    output logic [WORD_SIZE-1:0] io_out,
    input  logic [WORD_SIZE-1:0] io_in
);

    localparam int         AW = $clog2(DEPTH);
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    state_e               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 we_q, we_d;
    logic [WORD_SIZE-1:0] addr_q, addr_d;
    logic [WORD_SIZE-1:0] wdata_q, wdata_d;
    logic [WORD_SIZE-1:0] rd_q, rd_d;
    logic                 ram_src_q, ram_src_d;
    logic [WORD_SIZE-1:0] io_out_q, io_out_d;
    logic [WORD_SIZE-1:0] cyc_q, cyc_d;
    logic [WORD_SIZE-1:0] sync1_q, sync2_q;
    logic [WORD_SIZE-1:0] ram_rdata;
    logic                 commit, wr_en, rd_en;
    sel_e                 sel;

    assign sel = decode(32'(addr_q), DEPTH);

    // Every request spends at least one WAIT cycle; the counter adds WAIT_STATES more.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_req) begin
                    state_d = WAIT;
                    cnt_d   = WS;
                    we_d    = mem_we;
                    addr_d  = memory_addr;
                    wdata_d = memory_out;
                end
            end
            WAIT: begin
                cnt_d   = (cnt_q == 4'd0) ? cnt_q : cnt_q - 4'd1;
                commit  = (cnt_q == 4'd0);
                state_d = commit ? RESP : WAIT;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_en     = commit & we_q;
        rd_en     = commit & ~we_q;
        io_out_d  = (wr_en && sel == SEL_IO_OUT) ? wdata_q : io_out_q;
        cyc_d     = (wr_en && sel == SEL_CYC) ? '0 : cyc_q + WORD_SIZE'(1);
        ram_src_d = rd_en ? (sel == SEL_RAM) : ram_src_q;
        rd_d      = !rd_en             ? rd_q     :
                    (sel == SEL_IO_OUT) ? io_out_q :
                    (sel == SEL_IO_IN)  ? sync2_q  :
                    (sel == SEL_CYC)    ? cyc_q    : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_q      <= '0;
            ram_src_q <= 1'b0;
            io_out_q  <= '0;
            cyc_q     <= '0;
            sync1_q   <= '0;
            sync2_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rd_q      <= rd_d;
            ram_src_q <= ram_src_d;
            io_out_q  <= io_out_d;
            cyc_q     <= cyc_d;
            sync1_q   <= io_in;
            sync2_q   <= sync1_q;
        end
    end

    sync_ram #(
        .WIDTH(WORD_SIZE),
        .DEPTH(DEPTH)
    ) u_ram (
        .clk  (clk),
        .en   (commit && sel == SEL_RAM),
        .we   (we_q),
        .addr (addr_q[AW-1:0]),
        .wdata(wdata_q),
        .rdata(ram_rdata)
    );

    // RAM reads land in the RAM's own output register on the commit edge.
    assign memory_in = ram_src_q ? ram_rdata : rd_q;
    assign mem_ready = (state_q == RESP);
    assign mem_fault = (state_q == RESP) && (sel == SEL_NONE);
    assign io_out    = io_out_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench for mem_responder with WAIT_STATES=0 (index 0) and WAIT_STATES=3 (index 1).
module tb_mem_responder;

    localparam int LAT0 = 2;
    localparam int LAT1 = 5;

    typedef struct {
        int          lat;
        logic [15:0] rd;
        logic        flt;
        int          extra;
    } res_t;

    logic             clk = 1'b0;
    logic [1:0]       rst_n, req, we, rdy, flt;
    logic [1:0][15:0] addr, wd, rd, io_out, io_in;
    int               cyc = 0;
    int               rel = 0;
    int               checks = 0;
    int               errors = 0;
    res_t             expq[$];
    res_t             obsq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : dut
        mem_responder #(
            .WORD_SIZE  (16),
            .DEPTH      (1024),
            .WAIT_STATES(3 * g)
        ) u (
            .clk        (clk),
            .rst_n      (rst_n[g]),
            .mem_req    (req[g]),
            .mem_we     (we[g]),
            .memory_addr(addr[g]),
            .memory_out (wd[g]),
            .memory_in  (rd[g]),
            .mem_ready  (rdy[g]),
            .mem_fault  (flt[g]),
            .io_out     (io_out[g]),
            .io_in      (io_in[g])
        );
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push(input int lat, input logic [15:0] r, input logic f);
        res_t e;
        e.lat   = lat;
        e.rd    = r;
        e.flt   = f;
        e.extra = 0;
        expq.push_back(e);
    endtask

    // Called just after a negedge; the accept edge is the next posedge.
    task automatic txn(input int i, input logic w, input logic [15:0] a, input logic [15:0] d, input bit hold);
        res_t o;
        o.lat   = -1;
        o.rd    = '0;
        o.flt   = 1'b0;
        o.extra = 0;
        req[i]  = 1'b1;
        we[i]   = w;
        addr[i] = a;
        wd[i]   = d;
        @(posedge clk);
        for (int k = 1; k <= 40 && o.lat < 0; k++) begin
            @(negedge clk);
            if (rdy[i]) begin
                o.lat = k;
                o.rd  = rd[i];
                o.flt = flt[i];
            end
        end
        if (!hold) req[i] = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            o.extra += int'(rdy[i]);
            req[i] = 1'b0;
        end
        obsq.push_back(o);
    endtask

    task automatic test_reset();
        rst_n = 2'b00;
        req   = '0;
        we    = '0;
        addr  = '0;
        wd    = '0;
        io_in = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks += 4;
            if (rd[i] !== 16'h0) begin errors++; $display("FAIL reset memory_in[%0d]: got %h want 0000", i, rd[i]); end
            if (rdy[i] !== 1'b0) begin errors++; $display("FAIL reset mem_ready[%0d]: got %b want 0", i, rdy[i]); end
            if (flt[i] !== 1'b0) begin errors++; $display("FAIL reset mem_fault[%0d]: got %b want 0", i, flt[i]); end
            if (io_out[i] !== 16'h0) begin errors++; $display("FAIL reset io_out[%0d]: got %h want 0000", i, io_out[i]); end
        end
        rst_n = 2'b11;
        rel   = cyc;
    endtask

    task automatic test_ram();
        res_t e, o;
        push(LAT0, 16'h0000, 1'b0); txn(0, 1'b1, 16'h0005, 16'h1234, 1'b0);
        push(LAT0, 16'h1234, 1'b0); txn(0, 1'b0, 16'h0005, 16'h0000, 1'b0);
        push(LAT0, 16'h1234, 1'b0); txn(0, 1'b1, 16'h0000, 16'h0A0A, 1'b0);
        push(LAT0, 16'h0A0A, 1'b0); txn(0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        while (obsq.size() != 0) begin
            e = expq.pop_front();
            o = obsq.pop_front();
            checks += 4;
            if (o.lat !== e.lat) begin errors++; $display("FAIL ram latency: got %0d want %0d", o.lat, e.lat); end
            if (o.rd !== e.rd) begin errors++; $display("FAIL ram memory_in: got %h want %h", o.rd, e.rd); end
            if (o.flt !== e.flt) begin errors++; $display("FAIL ram mem_fault: got %b want %b", o.flt, e.flt); end
            if (o.extra !== e.extra) begin errors++; $display("FAIL ram extra_ready: got %0d want %0d", o.extra, e.extra); end
        end
    endtask

    task automatic test_hold();
        res_t e, o;
        push(LAT1, 16'h0000, 1'b0); txn(1, 1'b1, 16'h0007, 16'h1111, 1'b0);
        push(LAT1, 16'h0000, 1'b0); txn(1, 1'b1, 16'h0005, 16'h2222, 1'b0);
        push(LAT1, 16'h2222, 1'b0); txn(1, 1'b0, 16'h0005, 16'h0000, 1'b1);
        push(LAT1, 16'h1111, 1'b0); txn(1, 1'b0, 16'h0007, 16'h0000, 1'b1);
        while (obsq.size() != 0) begin
            e = expq.pop_front();
            o = obsq.pop_front();
            checks += 4;
            if (o.lat !== e.lat) begin errors++; $display("FAIL hold latency: got %0d want %0d", o.lat, e.lat); end
            if (o.rd !== e.rd) begin errors++; $display("FAIL hold memory_in: got %h want %h", o.rd, e.rd); end
            if (o.flt !== e.flt) begin errors++; $display("FAIL hold mem_fault: got %b want %b", o.flt, e.flt); end
            if (o.extra !== e.extra) begin errors++; $display("FAIL hold extra_ready: got %0d want %0d", o.extra, e.extra); end
        end
    endtask

    task automatic test_io();
        res_t e, o;
        push(LAT1, 16'h1111, 1'b0); txn(1, 1'b1, 16'hFFF0, 16'hBEEF, 1'b0);
        checks++;
        if (io_out[1] !== 16'hBEEF) begin errors++; $display("FAIL io_out after write: got %h want beef", io_out[1]); end
        push(LAT1, 16'hBEEF, 1'b0); txn(1, 1'b0, 16'hFFF0, 16'h0000, 1'b0);
        io_in[1] = 16'h00A5;
        repeat (3) @(negedge clk);
        push(LAT1, 16'h00A5, 1'b0); txn(1, 1'b0, 16'hFFF1, 16'h0000, 1'b0);
        push(LAT1, 16'h00A5, 1'b0); txn(1, 1'b1, 16'hFFF1, 16'h0F0F, 1'b0);
        push(LAT1, 16'h00A5, 1'b0); txn(1, 1'b0, 16'hFFF1, 16'h0000, 1'b0);
        checks++;
        if (io_out[1] !== 16'hBEEF) begin errors++; $display("FAIL io_out after io_in write: got %h want beef", io_out[1]); end
        while (obsq.size() != 0) begin
            e = expq.pop_front();
            o = obsq.pop_front();
            checks += 4;
            if (o.lat !== e.lat) begin errors++; $display("FAIL io latency: got %0d want %0d", o.lat, e.lat); end
            if (o.rd !== e.rd) begin errors++; $display("FAIL io memory_in: got %h want %h", o.rd, e.rd); end
            if (o.flt !== e.flt) begin errors++; $display("FAIL io mem_fault: got %b want %b", o.flt, e.flt); end
            if (o.extra !== e.extra) begin errors++; $display("FAIL io extra_ready: got %0d want %0d", o.extra, e.extra); end
        end
    endtask

    task automatic test_unmapped();
        res_t e, o;
        push(LAT0, 16'h1234, 1'b0); txn(0, 1'b0, 16'h0005, 16'h0000, 1'b0);
        push(LAT0, 16'h0000, 1'b1); txn(0, 1'b0, 16'h8000, 16'h0000, 1'b0);
        push(LAT0, 16'h0000, 1'b1); txn(0, 1'b1, 16'h8000, 16'hDEAD, 1'b0);
        push(LAT0, 16'h0A0A, 1'b0); txn(0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        push(LAT0, 16'h1234, 1'b0); txn(0, 1'b0, 16'h0005, 16'h0000, 1'b0);
        checks++;
        if (io_out[0] !== 16'h0000) begin errors++; $display("FAIL unmapped io_out: got %h want 0000", io_out[0]); end
        while (obsq.size() != 0) begin
            e = expq.pop_front();
            o = obsq.pop_front();
            checks += 4;
            if (o.lat !== e.lat) begin errors++; $display("FAIL unmapped latency: got %0d want %0d", o.lat, e.lat); end
            if (o.rd !== e.rd) begin errors++; $display("FAIL unmapped memory_in: got %h want %h", o.rd, e.rd); end
            if (o.flt !== e.flt) begin errors++; $display("FAIL unmapped mem_fault: got %b want %b", o.flt, e.flt); end
            if (o.extra !== e.extra) begin errors++; $display("FAIL unmapped extra_ready: got %0d want %0d", o.extra, e.extra); end
        end
    endtask

    // Commit edge of a request raised now is cyc+2 on the WAIT_STATES=0 unit.
    task automatic test_cycles();
        res_t        e, o;
        int          w;
        logic [15:0] v;
        v = 16'(cyc + 2 - rel - 1);
        push(LAT0, v, 1'b0); txn(0, 1'b0, 16'hFFF2, 16'h0000, 1'b0);
        w = cyc + 2;
        push(LAT0, v, 1'b0); txn(0, 1'b1, 16'hFFF2, 16'h0040, 1'b0);
        v = 16'(cyc + 2 - w - 1);
        push(LAT0, v, 1'b0); txn(0, 1'b0, 16'hFFF2, 16'h0000, 1'b0);
        repeat (65530) @(negedge clk);
        v = 16'(cyc + 2 - w - 1);
        push(LAT0, v, 1'b0); txn(0, 1'b0, 16'hFFF2, 16'h0000, 1'b0);
        while (obsq.size() != 0) begin
            e = expq.pop_front();
            o = obsq.pop_front();
            checks += 4;
            if (o.lat !== e.lat) begin errors++; $display("FAIL cycles latency: got %0d want %0d", o.lat, e.lat); end
            if (o.rd !== e.rd) begin errors++; $display("FAIL cycles memory_in: got %h want %h", o.rd, e.rd); end
            if (o.flt !== e.flt) begin errors++; $display("FAIL cycles mem_fault: got %b want %b", o.flt, e.flt); end
            if (o.extra !== e.extra) begin errors++; $display("FAIL cycles extra_ready: got %0d want %0d", o.extra, e.extra); end
        end
    endtask

    task automatic test_reset_mid();
        res_t e, o;
        int   seen;
        req[1]  = 1'b1;
        we[1]   = 1'b1;
        addr[1] = 16'h0007;
        wd[1]   = 16'h5555;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        rst_n[1] = 1'b0;
        #1;
        checks += 4;
        if (rd[1] !== 16'h0) begin errors++; $display("FAIL midreset memory_in: got %h want 0000", rd[1]); end
        if (rdy[1] !== 1'b0) begin errors++; $display("FAIL midreset mem_ready: got %b want 0", rdy[1]); end
        if (flt[1] !== 1'b0) begin errors++; $display("FAIL midreset mem_fault: got %b want 0", flt[1]); end
        if (io_out[1] !== 16'h0) begin errors++; $display("FAIL midreset io_out: got %h want 0000", io_out[1]); end
        req[1] = 1'b0;
        seen   = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            seen += int'(rdy[1]);
            if (k == 2) rst_n[1] = 1'b1;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL midreset stray_ready: got %0d want 0", seen); end
        push(LAT1, 16'h1111, 1'b0); txn(1, 1'b0, 16'h0007, 16'h0000, 1'b0);
        while (obsq.size() != 0) begin
            e = expq.pop_front();
            o = obsq.pop_front();
            checks += 4;
            if (o.lat !== e.lat) begin errors++; $display("FAIL midreset latency: got %0d want %0d", o.lat, e.lat); end
            if (o.rd !== e.rd) begin errors++; $display("FAIL midreset memory_in: got %h want %h", o.rd, e.rd); end
            if (o.flt !== e.flt) begin errors++; $display("FAIL midreset mem_fault: got %b want %b", o.flt, e.flt); end
            if (o.extra !== e.extra) begin errors++; $display("FAIL midreset extra_ready: got %0d want %0d", o.extra, e.extra); end
        end
    endtask

    initial begin
        test_reset();
        test_ram();
        test_hold();
        test_io();
        test_unmapped();
        test_cycles();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
